// File: rtl/l4_pkg.sv
// Shared constants, types and small arithmetic helpers for the layer_4 pooling stage.
package l4_pkg;

    localparam int DW   = 18;
    localparam int NCH  = 16;
    localparam int NGRP = 4;
    localparam int WIN  = 4;

    localparam int GW  = $clog2(NGRP);
    localparam int CW  = $clog2(NCH);
    localparam int FW  = $clog2(NCH * NGRP);
    localparam int WCW = $clog2(WIN);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    typedef logic signed [DW-1:0] feat_t;

    function automatic feat_t relu(input feat_t x);
        return (x < 0) ? feat_t'(0) : x;
    endfunction

    function automatic feat_t fmax(input feat_t a, input feat_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/l4_pool_buf.sv
// 64-entry feature store (NGRP rows x NCH cols), one write port, one registered row read.
// Read latency 1 cycle; a same-cycle write to the read row returns the old contents.
module l4_pool_buf
    import l4_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [GW-1:0]        wr_row,
    input  logic [CW-1:0]        wr_col,
    input  logic signed [DW-1:0] wr_dat,
    input  logic [GW-1:0]        rd_row,
    output logic signed [DW-1:0] rd_dat [NCH-1:0]
);

    logic signed [DW-1:0] mem_q [NGRP-1:0][NCH-1:0];

    // Storage is intentionally left unreset; only the read register clears.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_row][wr_col] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                rd_dat[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                rd_dat[i] <= mem_q[rd_row][i];
            end
        end
    end

endmodule

// File: rtl/layer_4.sv
// ReLU + 2x2 max-pool of a serial sample stream into 4x16 features; strt pulses one cycle after the last sample.
// dout follows grp_sel with 1-cycle latency; rdy drops while a full frame waits for tx_done.
module layer_4
    import l4_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vld_in,
    input  logic signed [DW-1:0] din_in,
    output logic                 rdy,
    input  logic                 tx_done,
    input  logic [GW-1:0]        grp_sel,
    output logic                 strt,
    output logic signed [DW-1:0] dout [NCH-1:0]
);

    state_t           state_q, state_d;
    logic [WCW-1:0]   win_cnt_q, win_cnt_d;
    logic [FW-1:0]    feat_cnt_q, feat_cnt_d;
    feat_t            run_max_q, run_max_d;
    logic             strt_q, strt_d;

    feat_t            relu_val;
    feat_t            pool_max;
    logic             accept;
    logic             last_smp;
    logic             last_feat;

    always_comb begin
        relu_val  = relu(din_in);
        pool_max  = (win_cnt_q == '0) ? relu_val : fmax(run_max_q, relu_val);
        // tx_done wins over vld_in, so the sample presented with it is dropped.
        accept    = (state_q == COLLECT) && vld_in && !tx_done;
        last_smp  = accept && (win_cnt_q == WCW'(WIN - 1));
        last_feat = last_smp && (feat_cnt_q == FW'(NCH * NGRP - 1));
    end

    always_comb begin
        state_d    = state_q;
        win_cnt_d  = win_cnt_q;
        feat_cnt_d = feat_cnt_q;
        run_max_d  = run_max_q;
        strt_d     = 1'b0;
        if (tx_done) begin
            state_d    = COLLECT;
            win_cnt_d  = '0;
            feat_cnt_d = '0;
            run_max_d  = '0;
        end else if (accept) begin
            run_max_d = pool_max;
            win_cnt_d = last_smp ? '0 : win_cnt_q + 1'b1;
            if (last_smp) begin
                feat_cnt_d = last_feat ? '0 : feat_cnt_q + 1'b1;
            end
            if (last_feat) begin
                state_d = FULL;
                strt_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= COLLECT;
            win_cnt_q  <= '0;
            feat_cnt_q <= '0;
            run_max_q  <= '0;
            strt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_cnt_q  <= win_cnt_d;
            feat_cnt_q <= feat_cnt_d;
            run_max_q  <= run_max_d;
            strt_q     <= strt_d;
        end
    end

    assign rdy  = (state_q == COLLECT);
    assign strt = strt_q;

    l4_pool_buf u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (last_smp),
        .wr_row (feat_cnt_q[FW-1:CW]),
        .wr_col (feat_cnt_q[CW-1:0]),
        .wr_dat (pool_max),
        .rd_row (grp_sel),
        .rd_dat (dout)
    );

endmodule

// File: tb/tb_layer_4.sv
// Directed bench for layer_4: frames of known patterns, checked against closed-form pooled values.
module tb_layer_4;
    import l4_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 vld_in;
    logic signed [DW-1:0] din_in;
    logic                 rdy;
    logic                 tx_done;
    logic [GW-1:0]        grp_sel;
    logic                 strt;
    logic signed [DW-1:0] dout [NCH-1:0];

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    layer_4 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .vld_in  (vld_in),
        .din_in  (din_in),
        .rdy     (rdy),
        .tx_done (tx_done),
        .grp_sel (grp_sel),
        .strt    (strt),
        .dout    (dout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pattern modes: 0 = -5, 1 = n-128, 2 = 7, 3 = 200-n, 4 = 50, 5 = 9.
    function automatic int sample_val(input int mode, input int n);
        case (mode)
            0:       return -5;
            1:       return n - 128;
            2:       return 7;
            3:       return 200 - n;
            4:       return 50;
            default: return 9;
        endcase
    endfunction

    function automatic int exp_feat(input int mode, input int k);
        case (mode)
            1:       return (4 * k - 125 > 0) ? 4 * k - 125 : 0;
            2:       return 7;
            3:       return (200 - 4 * k > 0) ? 200 - 4 * k : 0;
            default: return 0;
        endcase
    endfunction

    task automatic feed(input string tag, input int mode, input int nsmp, input bit gaps, input bit exp_end);
        int early;
        logic last_strt;
        early     = 0;
        last_strt = 1'b0;
        for (int i = 0; i < nsmp; i++) begin
            vld_in = 1'b1;
            din_in = DW'(sample_val(mode, i));
            step();
            if (i == nsmp - 1) last_strt = strt;
            else if (strt) early++;
            if (gaps && i != nsmp - 1) begin
                vld_in = 1'b0;
                din_in = DW'(1000);
                step();
                if (strt) early++;
            end
        end
        vld_in = 1'b0;
        chk({tag, "_early_strt"}, early, 0);
        chk({tag, "_end_strt"}, last_strt, exp_end);
        if (exp_end) chk({tag, "_rdy_full"}, rdy, 0);
    endtask

    task automatic check_groups(input string tag, input int mode);
        for (int g = 0; g < NGRP; g++) begin
            grp_sel = GW'(g);
            step();
            for (int c = 0; c < NCH; c++) begin
                chk($sformatf("%s_g%0d_c%0d", tag, g, c), dout[c], exp_feat(mode, NCH * g + c));
            end
        end
    endtask

    task automatic release_frame(input string tag);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk({tag, "_rdy"}, rdy, 1);
        chk({tag, "_strt"}, strt, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        vld_in  = 1'b0;
        din_in  = '0;
        tx_done = 1'b0;
        grp_sel = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", rdy, 1);
        chk("rst_strt", strt, 0);
        for (int c = 0; c < NCH; c++) chk($sformatf("rst_dout%0d", c), dout[c], 0);
        rst_n = 1'b1;
        step();

        // All-negative frame pools to zero everywhere.
        feed("neg", 0, 256, 1'b0, 1'b1);
        step();
        chk("neg_strt_once", strt, 0);
        check_groups("neg", 0);
        release_frame("neg_rel");

        // Contiguous ramp, plus grp_sel latency.
        feed("ramp", 1, 256, 1'b0, 1'b1);
        check_groups("ramp", 1);
        grp_sel = 2'd0;
        chk("lat_old_c0", dout[0], 67);
        chk("lat_old_c15", dout[15], 127);
        step();
        chk("lat_new_c0", dout[0], 0);
        grp_sel = 2'd3;
        step();
        release_frame("ramp_rel");

        // Ramp with vld_in gaps between samples.
        feed("gap", 1, 256, 1'b1, 1'b1);
        check_groups("gap", 1);

        // FULL ignores incoming samples.
        vld_in = 1'b1;
        din_in = DW'(1000);
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("hold%0d_rdy", i), rdy, 0);
            chk($sformatf("hold%0d_strt", i), strt, 0);
            chk($sformatf("hold%0d_c15", i), dout[15], 127);
        end
        vld_in = 1'b0;
        release_frame("hold_rel");
        feed("c7", 2, 256, 1'b0, 1'b1);
        check_groups("c7", 2);
        release_frame("c7_rel");

        // Abort a partial frame; the sample alongside tx_done is dropped.
        feed("part", 4, 100, 1'b0, 1'b0);
        vld_in  = 1'b1;
        din_in  = DW'(999);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        vld_in  = 1'b0;
        chk("abort_strt", strt, 0);
        chk("abort_rdy", rdy, 1);
        feed("down", 3, 256, 1'b0, 1'b1);
        check_groups("down", 3);
        release_frame("down_rel");

        // Reset mid-frame.
        feed("pre_rst", 5, 130, 1'b0, 1'b0);
        grp_sel = 2'd1;
        rst_n   = 1'b0;
        #1;
        chk("mrst_strt", strt, 0);
        chk("mrst_rdy", rdy, 1);
        for (int c = 0; c < NCH; c++) chk($sformatf("mrst_dout%0d", c), dout[c], 0);
        step();
        rst_n = 1'b1;
        step();
        feed("post_rst", 1, 256, 1'b0, 1'b1);
        check_groups("post_rst", 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
